display_demux: RTL and testbench

Receive-side counterpart of the 4-digit scanned seven-segment driver. It samples the multiplexed active-low `seg`/`an` bus, demultiplexes it per digit, and decodes each captured pattern back to a hex value. Once every digit has been seen it publishes a coherent frame snapshot. It sits on the board-side display bus as a self-check/readback monitor, feeding the test controller and debug logic.

---
 rtl/display_demux_if.sv | 27 ++
 rtl/display_demux.sv | 200 ++++++++++++++++++++
 tb/tb_display_demux.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_demux_if.sv
// Display bus between a scanned seven-segment driver and its readback monitor.
interface display_demux_if;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned VAL_W   = 16;

    logic [SEG_W-1:0]   seg_in;
    logic [NUM_DIG-1:0] an_in;
    logic [VAL_W-1:0]   frame_val;
    logic [NUM_DIG-1:0] frame_ok;
    logic [NUM_DIG-1:0] frame_blank;
    logic               frame_strobe;
    logic               an_err;
    logic               stall;

    // Driver side: drives the scanned bus, observes decoded frames.
    modport master (
        output seg_in, an_in,
        input  frame_val, frame_ok, frame_blank, frame_strobe, an_err, stall
    );

    // Monitor side: samples the scanned bus, publishes decoded frames.
    modport slave (
        input  seg_in, an_in,
        output frame_val, frame_ok, frame_blank, frame_strobe, an_err, stall
    );
endinterface

// File: rtl/display_demux.sv
// Readback monitor for a 4-digit scanned active-low seven-segment bus:
// demultiplexes per digit, decodes glyphs to hex and publishes coherent frames.
module display_demux #(
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    display_demux_if.slave bus
);
    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned GLY_W   = 7;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned VAL_W   = NUM_DIG * NIB_W;
    localparam int unsigned STAB_W  = 4;
    localparam int unsigned LOW_W   = 3;
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [STAB_W-1:0]  STAB_MAX   = '1;
    localparam logic [STAB_W-1:0]  STAB_TGT   = STAB_W'(STABLE_CYCLES);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [GLY_W-1:0]   GLY_BLANK  = 7'h7F;
    localparam logic [NUM_DIG-1:0] ALL_SEEN   = '1;

    typedef enum logic {COLLECT, PUBLISH} state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [NUM_DIG-1:0] an_q, an_d;
    logic [STAB_W-1:0]  stab_cnt_q, stab_cnt_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [GLY_W-1:0]   raw_q [NUM_DIG];
    logic [GLY_W-1:0]   raw_d [NUM_DIG];
    logic [NUM_DIG-1:0] seen_q, seen_d;
    logic [VAL_W-1:0]   frame_val_q, frame_val_d;
    logic [NUM_DIG-1:0] frame_ok_q, frame_ok_d;
    logic [NUM_DIG-1:0] frame_blank_q, frame_blank_d;
    logic               frame_strobe_q, frame_strobe_d;
    logic               an_err_q, an_err_d;
    logic               stall_q, stall_d;

    logic [LOW_W-1:0]   an_low_cnt;
    logic               capture;
    logic [NUM_DIG-1:0] cap_mask;
    logic               timeout;
    logic [VAL_W-1:0]   dec_val;
    logic [NUM_DIG-1:0] dec_ok;
    logic [NUM_DIG-1:0] dec_blank;
    logic               dp_unused;

    // Active-low {g..a} glyph to {legal, hex nibble}; anything else is illegal.
    function automatic logic [NIB_W:0] decode_glyph(input logic [GLY_W-1:0] pat);
        logic [NIB_W:0] res;
        case (pat)
            7'h40:   res = {1'b1, 4'h0};
            7'h79:   res = {1'b1, 4'h1};
            7'h24:   res = {1'b1, 4'h2};
            7'h30:   res = {1'b1, 4'h3};
            7'h19:   res = {1'b1, 4'h4};
            7'h12:   res = {1'b1, 4'h5};
            7'h02:   res = {1'b1, 4'h6};
            7'h78:   res = {1'b1, 4'h7};
            7'h00:   res = {1'b1, 4'h8};
            7'h10:   res = {1'b1, 4'h9};
            7'h08:   res = {1'b1, 4'hA};
            7'h03:   res = {1'b1, 4'hB};
            7'h46:   res = {1'b1, 4'hC};
            7'h21:   res = {1'b1, 4'hD};
            7'h06:   res = {1'b1, 4'hE};
            7'h0E:   res = {1'b1, 4'hF};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Decimal point carries no digit information.
    assign dp_unused = seg_q[SEG_W-1];

    // Qualify a capture: one digit enabled and held for exactly STABLE_CYCLES.
    always_comb begin
        an_low_cnt = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            an_low_cnt = an_low_cnt + LOW_W'(!an_q[i]);
        end
        capture  = (an_low_cnt == LOW_W'(1)) && (stab_cnt_q == STAB_TGT);
        cap_mask = capture ? ~an_q : '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            raw_d[i] = cap_mask[i] ? seg_q[GLY_W-1:0] : raw_q[i];
        end
    end

    // Decode the post-capture raw patterns so a completing capture is published at once.
    always_comb begin
        dec_val   = '0;
        dec_ok    = '0;
        dec_blank = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            {dec_ok[i], dec_val[i*NIB_W +: NIB_W]} = decode_glyph(raw_d[i]);
            dec_blank[i] = (raw_d[i] == GLY_BLANK);
        end
    end

    // Input stage, stability/idle counters, error flags and frame FSM next state.
    always_comb begin
        seg_d          = bus.seg_in;
        an_d           = bus.an_in;
        stab_cnt_d     = stab_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        seen_d         = seen_q | cap_mask;
        state_d        = state_q;
        frame_val_d    = frame_val_q;
        frame_ok_d     = frame_ok_q;
        frame_blank_d  = frame_blank_q;
        frame_strobe_d = 1'b0;
        an_err_d       = an_err_q | (an_low_cnt >= LOW_W'(2));
        stall_d        = stall_q;

        if (an_d != an_q) begin
            stab_cnt_d = STAB_W'(1);
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end

        if (capture) begin
            idle_cnt_d = '0;
            stall_d    = 1'b0;
        end else if (idle_cnt_q != IDLE_LIMIT) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
        timeout = !capture && (idle_cnt_d == IDLE_LIMIT);

        case (state_q)
            COLLECT: begin
                if (seen_d == ALL_SEEN) begin
                    state_d        = PUBLISH;
                    frame_val_d    = dec_val;
                    frame_ok_d     = dec_ok;
                    frame_blank_d  = dec_blank;
                    frame_strobe_d = 1'b1;
                end
            end
            PUBLISH: begin
                // Start the next frame; a capture landing now already counts toward it.
                seen_d  = cap_mask;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase

        if (timeout) begin
            seen_d  = '0;
            stall_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= COLLECT;
            seg_q          <= '1;
            an_q           <= '1;
            stab_cnt_q     <= '0;
            idle_cnt_q     <= '0;
            seen_q         <= '0;
            frame_val_q    <= '0;
            frame_ok_q     <= '0;
            frame_blank_q  <= '0;
            frame_strobe_q <= 1'b0;
            an_err_q       <= 1'b0;
            stall_q        <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                raw_q[i] <= GLY_BLANK;
            end
        end else begin
            state_q        <= state_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            stab_cnt_q     <= stab_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            seen_q         <= seen_d;
            frame_val_q    <= frame_val_d;
            frame_ok_q     <= frame_ok_d;
            frame_blank_q  <= frame_blank_d;
            frame_strobe_q <= frame_strobe_d;
            an_err_q       <= an_err_d;
            stall_q        <= stall_d;
            for (int i = 0; i < NUM_DIG; i++) begin
                raw_q[i] <= raw_d[i];
            end
        end
    end

    assign bus.frame_val    = frame_val_q;
    assign bus.frame_ok     = frame_ok_q;
    assign bus.frame_blank  = frame_blank_q;
    assign bus.frame_strobe = frame_strobe_q;
    assign bus.an_err       = an_err_q;
    assign bus.stall        = stall_q;
endmodule

// File: tb/tb_display_demux.sv
// Directed bench for display_demux: one instance with STABLE_CYCLES=1, one with 3.
module tb_display_demux;
    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   n_strobe_a = 0;
    int   n_strobe_b = 0;
    int   snap;
    logic [7:0] seg_a [4];

    display_demux_if bus_a ();
    display_demux_if bus_b ();

    display_demux #(.STABLE_CYCLES(1), .TIMEOUT(TMO)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    display_demux #(.STABLE_CYCLES(3), .TIMEOUT(TMO)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    // Count strobe cycles seen at each rising edge.
    always @(posedge clk) begin
        if (bus_a.frame_strobe === 1'b1) n_strobe_a <= n_strobe_a + 1;
        if (bus_b.frame_strobe === 1'b1) n_strobe_b <= n_strobe_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_a(input int dig);
        if (dig < 0) begin
            bus_a.an_in  = 4'hF;
            bus_a.seg_in = 8'hFF;
        end else begin
            bus_a.an_in  = ~(4'b0001 << dig);
            bus_a.seg_in = seg_a[dig];
        end
    endtask

    task automatic visit_b(input int dig, input logic [7:0] seg, input int len);
        bus_b.an_in  = ~(4'b0001 << dig);
        bus_b.seg_in = seg;
        cyc(len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        drive_a(-1);
        bus_b.an_in  = 4'hF;
        bus_b.seg_in = 8'hFF;
        seg_a        = '{8'hC0, 8'hF9, 8'hFF, 8'hFF};

        // Reset defaults and idle timeout
        cyc(3);
        reset_n = 1'b1;
        chk("rst_frame_val", 32'(bus_a.frame_val), 32'h0);
        chk("rst_frame_ok", 32'(bus_a.frame_ok), 32'h0);
        chk("rst_frame_blank", 32'(bus_a.frame_blank), 32'h0);
        chk("rst_strobe", 32'(bus_a.frame_strobe), 32'h0);
        chk("rst_an_err", 32'(bus_a.an_err), 32'h0);
        chk("rst_stall", 32'(bus_a.stall), 32'h0);
        cyc(10);
        chk("idle_stall_early", 32'(bus_a.stall), 32'h0);
        cyc(10);
        chk("idle_stall_timeout", 32'(bus_a.stall), 32'h1);
        cyc(12);
        chk("idle_no_strobe", 32'(n_strobe_a), 32'h0);

        // Single-frame decode, one digit per clock
        reset_n = 1'b0;
        cyc(1);
        drive_a(0);
        reset_n = 1'b1;
        for (int j = 1; j <= 21; j++) begin
            cyc(1);
            if (j == 13) seg_a[2] = 8'hD5;
            chk("scan_strobe", 32'(bus_a.frame_strobe), 32'(j >= 5 && j % 4 == 1));
            if (j == 5) begin
                chk("first_frame_val", 32'(bus_a.frame_val), 32'h0010);
                chk("first_frame_ok", 32'(bus_a.frame_ok), 32'h3);
                chk("first_frame_blank", 32'(bus_a.frame_blank), 32'hC);
            end
            if (j <= 19) drive_a(j % 4);
            else drive_a(-1);
        end
        // Illegal glyph 55 on digit 2
        chk("illegal_frame_val", 32'(bus_a.frame_val), 32'h0010);
        chk("illegal_frame_ok", 32'(bus_a.frame_ok), 32'h3);
        chk("illegal_frame_blank", 32'(bus_a.frame_blank), 32'h8);

        // Stability gate: only 3-cycle visits capture
        chk("b_stall_idle", 32'(bus_b.stall), 32'h1);
        snap = n_strobe_b;
        visit_b(0, 8'h8E, 2);
        visit_b(1, 8'h92, 3);
        visit_b(2, 8'h8E, 2);
        visit_b(3, 8'h88, 3);
        chk("b_stall_cleared", 32'(bus_b.stall), 32'h0);
        chk("b_round1_no_strobe", 32'(n_strobe_b), 32'(snap));
        visit_b(0, 8'hB0, 3);
        visit_b(1, 8'h86, 2);
        visit_b(2, 8'hF8, 3);
        chk("b_round2_no_strobe_yet", 32'(n_strobe_b), 32'(snap));
        chk("b_strobe_low", 32'(bus_b.frame_strobe), 32'h0);
        bus_b.an_in  = 4'hF;
        bus_b.seg_in = 8'hFF;
        cyc(1);
        chk("b_strobe", 32'(bus_b.frame_strobe), 32'h1);
        chk("b_frame_val", 32'(bus_b.frame_val), 32'hA753);
        chk("b_frame_ok", 32'(bus_b.frame_ok), 32'hF);
        chk("b_frame_blank", 32'(bus_b.frame_blank), 32'h0);

        // Timeout mid-frame after capturing digits 0 and 1
        drive_a(0);
        cyc(1);
        drive_a(1);
        cyc(1);
        drive_a(-1);
        cyc(1);
        snap = n_strobe_a;
        cyc(8);
        chk("tmo_stall_early", 32'(bus_a.stall), 32'h0);
        cyc(12);
        chk("tmo_stall", 32'(bus_a.stall), 32'h1);
        chk("tmo_frame_val", 32'(bus_a.frame_val), 32'h0010);
        chk("tmo_frame_ok", 32'(bus_a.frame_ok), 32'h3);
        chk("tmo_frame_blank", 32'(bus_a.frame_blank), 32'h8);
        chk("tmo_no_strobe", 32'(n_strobe_a), 32'(snap));

        // an fault: two digits enabled never captures and sets sticky an_err
        chk("an_err_clear", 32'(bus_a.an_err), 32'h0);
        bus_a.an_in  = 4'b1100;
        bus_a.seg_in = 8'hF9;
        cyc(1);
        drive_a(-1);
        cyc(1);
        chk("an_err_set", 32'(bus_a.an_err), 32'h1);
        chk("an_fault_no_capture", 32'(bus_a.stall), 32'h1);
        cyc(5);
        chk("an_err_sticky", 32'(bus_a.an_err), 32'h1);

        // Resume: frame needs all four digits after the timeout
        seg_a = '{8'hA4, 8'hA1, 8'hC6, 8'hFF};
        snap  = n_strobe_a;
        drive_a(2);
        cyc(1);
        chk("resume_stall_held", 32'(bus_a.stall), 32'h1);
        drive_a(3);
        cyc(1);
        chk("resume_stall_clear", 32'(bus_a.stall), 32'h0);
        drive_a(0);
        cyc(1);
        drive_a(1);
        cyc(1);
        chk("resume_partial_strobe", 32'(bus_a.frame_strobe), 32'h0);
        chk("resume_partial_count", 32'(n_strobe_a), 32'(snap));
        drive_a(-1);
        cyc(1);
        chk("resume_strobe", 32'(bus_a.frame_strobe), 32'h1);
        chk("resume_frame_val", 32'(bus_a.frame_val), 32'h0CD2);
        chk("resume_frame_ok", 32'(bus_a.frame_ok), 32'h7);
        chk("resume_frame_blank", 32'(bus_a.frame_blank), 32'h8);

        // Async reset pulse after three captures
        cyc(2);
        drive_a(0);
        cyc(1);
        drive_a(1);
        cyc(1);
        drive_a(2);
        cyc(1);
        drive_a(-1);
        cyc(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_frame_val", 32'(bus_a.frame_val), 32'h0);
        chk("arst_frame_ok", 32'(bus_a.frame_ok), 32'h0);
        chk("arst_frame_blank", 32'(bus_a.frame_blank), 32'h0);
        chk("arst_an_err", 32'(bus_a.an_err), 32'h0);
        #1;
        reset_n = 1'b1;
        snap = n_strobe_a;
        drive_a(3);
        cyc(1);
        drive_a(-1);
        cyc(1);
        chk("arst_no_stale_strobe", 32'(bus_a.frame_strobe), 32'h0);
        cyc(1);
        chk("arst_no_stale_count", 32'(n_strobe_a), 32'(snap));
        drive_a(0);
        cyc(1);
        drive_a(1);
        cyc(1);
        drive_a(2);
        cyc(1);
        drive_a(-1);
        cyc(1);
        chk("arst_fresh_strobe", 32'(bus_a.frame_strobe), 32'h1);
        chk("arst_fresh_val", 32'(bus_a.frame_val), 32'h0CD2);
        chk("arst_fresh_ok", 32'(bus_a.frame_ok), 32'h7);
        chk("arst_fresh_blank", 32'(bus_a.frame_blank), 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
